tt_um_sub8_serial: RTL and testbench
====================================

Name: tt_um_sub8_serial

Overview:
Bit-serial 8-bit subtractor tile. It computes A - B one bit per clock, LSB first, with the same pin-level interface as the 8-bit adder tile.
- Operands arrive as bytes on ui_in and are captured by strobes on uio_in.
- The result is registered on uo_out.
- Status flags are driven on the upper uio pins.

It is the inverse arithmetic companion to the adder, and is sequential so the team can exercise a start/busy/done handshake through the pin mux.

Parameters:
WIDTH, 8, operand/result width; pin mapping supports only 8.
CNT_W, 3, bit-counter width, equal to clog2(WIDTH).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  design-selected flag; ignored by logic.
ui_in  input  8  operand data byte.
uio_in  input  8  [0] load_a strobe, [1] load_b strobe, [2] start strobe, [7:3] unused.
uo_out  output  8  registered difference.
uio_out  output  8  [4] busy, [5] done, [6] borrow, [7] zero, [3:0] = 0 (see Optional Feature for [3]).
uio_oe  output  8  constant 8'hF0 (8'hF8 with the optional feature).

Behaviour:
- Reset is asynchronous on rst_n low. It clears:
  - op_a and op_b registers
  - both shift registers
  - the counter
  - result register (uo_out = 0)
  - busy, done, borrow and zero flags
  - the previous-strobe registers
  - state, which returns to IDLE.
- Strobes act on rising edge only. Each strobe bit is registered; edge = in & ~prev. A level held high does not retrigger.
- load_a / load_b edges:
  - Capture ui_in into op_a / op_b on the edge cycle, in any state except RUN.
  - Ignored in RUN.
- States: IDLE, RUN, DONE.
- start edge in IDLE or DONE:
  - Shift registers load from op_a/op_b values as they stand before this cycle's edge. A simultaneous load updates op_x for the next start only.
  - Borrow-in is cleared, counter is cleared, done is cleared, busy is set, state goes to RUN.
- start edge in RUN: ignored.
- RUN, each cycle:
  - d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - d is shifted into the MSB of the difference shift register; both operand shift registers shift right.
  - The counter increments.
  - RUN lasts exactly WIDTH (8) cycles.
- Final RUN cycle (counter = 7):
  - uo_out <= full difference, equal to (A - B) mod 256.
  - borrow <= final bout, equal to (A < B unsigned).
  - zero <= (difference == 0).
  - busy <= 0, done <= 1, state goes to DONE.
- Latency: uo_out and done update 9 clock edges after the edge where the start pin rises (1 edge-detect register + 8 RUN cycles).
- uo_out and the flags hold their previous values throughout RUN and only change at completion.
- done is a sticky level in DONE and clears on the next accepted start.
- Reset asserted mid-RUN aborts the operation; no partial result ever appears on uo_out.

Optional Feature:
Macro SUB8_SIGNED_OVF_EN.
- Defined:
  - uio_out[3] = ovf, the two's-complement overflow of the subtraction: (A7 != B7) & (D7 != A7).
  - ovf is registered at completion alongside borrow and cleared by reset.
  - uio_oe = 8'hF8.
- Undefined: uio_out[3] = 0 and uio_oe = 8'hF0.

Decomposition:
Package sub8_pkg holds:
- WIDTH, CNT_W
- pin index constants (LOAD_A_BIT = 0, LOAD_B_BIT = 1, START_BIT = 2, BUSY_BIT = 4, DONE_BIT = 5, BORROW_BIT = 6, ZERO_BIT = 7, OVF_BIT = 3)
- the state enum {IDLE, RUN, DONE}.

One sub-module, sub8_fs_cell: a 1-bit combinational full subtractor with inputs a, b, bin and outputs d, bout. The top module instantiates it once in the serial datapath.

Test Plan:
- load_a 0x13, load_b 0x07, start -> after 9 edges uo_out = 0x0C, done = 1, borrow = 0, zero = 0; busy high for exactly 8 cycles.
- A = 0x0F, B = 0xF0, start -> uo_out = 0x1F, borrow = 1, zero = 0.
- A = 0x55, B = 0x55 -> uo_out = 0x00, zero = 1, borrow = 0. Then hold start high for 20 cycles -> no second run (busy stays 0).
- Start 0x13 - 0x07; at RUN cycle 3, pulse start and load_a = 0xFF -> both ignored, uo_out = 0x0C. Then a new start gives 0x0C again (op_a unchanged).
- Previous result 0x0C; start 0xF0 - 0x0F; assert rst_n low at RUN cycle 4 -> uo_out = 0 and all flags 0 immediately; after release, state IDLE and busy = 0.
- With SUB8_SIGNED_OVF_EN: A = 0x80, B = 0x01 -> uo_out = 0x7F, ovf = 1, borrow = 0, uio_oe = 0xF8. Without the macro: uio_out[3] = 0 and uio_oe = 0xF0.

Source files
------------

// File: rtl/sub8_pkg.sv
// Shared constants, pin indices and state encoding for the bit-serial 8-bit subtractor tile.
package sub8_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  localparam int LOAD_A_BIT = 0;
  localparam int LOAD_B_BIT = 1;
  localparam int START_BIT  = 2;
  localparam int OVF_BIT    = 3;
  localparam int BUSY_BIT   = 4;
  localparam int DONE_BIT   = 5;
  localparam int BORROW_BIT = 6;
  localparam int ZERO_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub8_fs_cell.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow out.
module sub8_fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_sub8_serial.sv
// Bit-serial 8-bit subtractor tile (A - B, LSB first) with start/busy/done handshake.
// Optional signed overflow flag on uio_out[3] when SUB8_SIGNED_OVF_EN is defined.
module tt_um_sub8_serial
  import sub8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic [CNT_W-1:0] cnt;
  logic             bin;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             borrow;
  logic             zero;
  logic [2:0]       strb_in;
  logic [2:0]       strb_prev;
  logic [2:0]       strb_edge;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] diff_next;
`ifdef SUB8_SIGNED_OVF_EN
  logic             ovf;
`endif

  wire unused = &{1'b0, ena, uio_in[7:3]};

  // Strobes are registered first, then compared with their previous value.
  assign strb_edge = strb_in & ~strb_prev;
  assign diff_next = {d, sh_d[WIDTH-1:1]};

  sub8_fs_cell u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  // Control FSM and serial datapath; results only commit on the last RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= 8'h00;
      op_b      <= 8'h00;
      sh_a      <= 8'h00;
      sh_b      <= 8'h00;
      sh_d      <= 8'h00;
      cnt       <= 3'd0;
      bin       <= 1'b0;
      result    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      strb_in   <= 3'b000;
      strb_prev <= 3'b000;
`ifdef SUB8_SIGNED_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      strb_in   <= uio_in[START_BIT:LOAD_A_BIT];
      strb_prev <= strb_in;
      case (state)
        IDLE, DONE: begin
          if (strb_edge[LOAD_A_BIT]) begin
            op_a <= ui_in;
          end
          if (strb_edge[LOAD_B_BIT]) begin
            op_b <= ui_in;
          end
          // Shift registers take the operands as they were before any same-cycle load.
          if (strb_edge[START_BIT]) begin
            sh_a  <= op_a;
            sh_b  <= op_b;
            bin   <= 1'b0;
            cnt   <= 3'd0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sh_d <= diff_next;
          sh_a <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          bin  <= bout;
          cnt  <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            result <= diff_next;
            borrow <= bout;
            zero   <= (diff_next == 8'h00);
`ifdef SUB8_SIGNED_OVF_EN
            // sh_a[0]/sh_b[0] hold the operand sign bits on the final cycle.
            ovf    <= (sh_a[0] != sh_b[0]) && (d != sh_a[0]);
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pin mux for the status flags.
  always_comb begin
    uio_out             = 8'h00;
    uio_out[BUSY_BIT]   = busy;
    uio_out[DONE_BIT]   = done;
    uio_out[BORROW_BIT] = borrow;
    uio_out[ZERO_BIT]   = zero;
`ifdef SUB8_SIGNED_OVF_EN
    uio_out[OVF_BIT]    = ovf;
`else
    uio_out[OVF_BIT]    = 1'b0;
`endif
  end

  assign uo_out = result;

`ifdef SUB8_SIGNED_OVF_EN
  assign uio_oe = 8'hF8;
`else
  assign uio_oe = 8'hF0;
`endif

endmodule

// File: tb/tb_tt_um_sub8_serial.sv
// Directed bench for tt_um_sub8_serial with an arithmetic reference model checked every cycle.
module tb_tt_um_sub8_serial;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  tt_um_sub8_serial dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SUB8_SIGNED_OVF_EN
  localparam logic [7:0] EXP_OE  = 8'hF8;
  localparam bit         OVF_ON  = 1'b1;
`else
  localparam logic [7:0] EXP_OE  = 8'hF0;
  localparam bit         OVF_ON  = 1'b0;
`endif

  // Reference model: strobe sync + rising edge, 8-cycle job, result by plain arithmetic.
  logic [2:0] m_s1, m_s2;
  logic [7:0] m_a, m_b, m_ja, m_jb, m_res;
  logic       m_busy, m_done, m_bor, m_zero, m_ovf;
  int         m_left;
  logic [7:0] m_diff;
  logic [2:0] m_edge;

  assign m_diff = m_ja - m_jb;
  assign m_edge = m_s1 & ~m_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 3'b000; m_s2 <= 3'b000;
      m_a <= 8'h00; m_b <= 8'h00; m_ja <= 8'h00; m_jb <= 8'h00; m_res <= 8'h00;
      m_busy <= 1'b0; m_done <= 1'b0; m_bor <= 1'b0; m_zero <= 1'b0; m_ovf <= 1'b0;
      m_left <= 0;
    end else begin
      m_s1 <= uio_in[2:0];
      m_s2 <= m_s1;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_res  <= m_diff;
          m_bor  <= (m_ja < m_jb);
          m_zero <= (m_diff == 8'h00);
          m_ovf  <= (m_ja[7] != m_jb[7]) && (m_diff[7] != m_ja[7]);
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else begin
        if (m_edge[0]) m_a <= ui_in;
        if (m_edge[1]) m_b <= ui_in;
        if (m_edge[2]) begin
          m_ja <= m_a; m_jb <= m_b;
          m_left <= 8; m_busy <= 1'b1; m_done <= 1'b0;
        end
      end
    end
  end

  function automatic logic [7:0] model_uio();
    return {m_zero, m_bor, m_done, m_busy, (OVF_ON ? m_ovf : 1'b0), 3'b000};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int bitn, input logic [7:0] v);
    ui_in = v;
    uio_in[bitn] = 1'b1;
    tick();
    uio_in[bitn] = 1'b0;
    tick();
    tick();
  endtask

  // Raise start and wait for completion; mode 0 plain, 1 hold start, 2 mid-run strobes, 3 mid-run reset.
  task automatic do_run(input int mode, output int lat, output int busy_n);
    bit got;
    got = 1'b0;
    lat = 0;
    busy_n = 0;
    uio_in[2] = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (mode != 1 && n == 1) uio_in[2] = 1'b0;
      if (mode == 2 && n == 4) begin
        ui_in = 8'hFF; uio_in[0] = 1'b1; uio_in[2] = 1'b1;
      end
      if (mode == 2 && n == 5) begin
        uio_in[0] = 1'b0; uio_in[2] = 1'b0;
      end
      if (mode == 3 && n == 6) begin
        rst_n = 1'b0;
        #1;
        check("mid_reset_uo", uo_out, 8'h00);
        check("mid_reset_flags", uio_out, 8'h00);
        got = 1'b1;
        break;
      end
      if (uio_out[4]) busy_n++;
      if (uio_out[5] && n > 1) begin
        lat = n - 1;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fails++;
      tests++;
      $display("FAIL run_timeout: got no done expected done within 30 cycles");
    end
  endtask

  int lat, bn;

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    fork
      forever begin
        @(negedge clk);
        check("model_uo", uo_out, m_res);
        check("model_uio", uio_out, model_uio());
        check("model_oe", uio_oe, EXP_OE);
      end
    join_none

    repeat (3) tick();
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    check("reset_oe", uio_oe, EXP_OE);
    rst_n = 1'b1;
    tick();

    // 0x13 - 0x07
    load(0, 8'h13); load(1, 8'h07);
    do_run(0, lat, bn);
    check("t1_uo", uo_out, 8'h0C);
    check("t1_flags", uio_out & 8'hE0, 8'h20);
    check("t1_latency", 8'(lat), 8'd9);
    check("t1_busy_cycles", 8'(bn), 8'd8);

    // 0x0F - 0xF0 borrows
    load(0, 8'h0F); load(1, 8'hF0);
    do_run(0, lat, bn);
    check("t2_uo", uo_out, 8'h1F);
    check("t2_flags", uio_out & 8'hE8, 8'h60);

    // 0x55 - 0x55 with start held high
    load(0, 8'h55); load(1, 8'h55);
    do_run(1, lat, bn);
    check("t3_uo", uo_out, 8'h00);
    check("t3_flags", uio_out & 8'hE0, 8'hA0);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("t3_no_rerun_busy", {7'd0, uio_out[4]}, 8'h00);
    end
    uio_in[2] = 1'b0;
    tick(); tick();

    // Strobes during RUN are ignored
    load(0, 8'h13); load(1, 8'h07);
    do_run(2, lat, bn);
    check("t4_uo", uo_out, 8'h0C);
    tick(); tick();
    do_run(0, lat, bn);
    check("t4_rerun_uo", uo_out, 8'h0C);
    check("t4_rerun_latency", 8'(lat), 8'd9);

    // Reset mid-run
    load(0, 8'hF0); load(1, 8'h0F);
    do_run(3, lat, bn);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t5_after_uo", uo_out, 8'h00);
    check("t5_after_flags", uio_out, 8'h00);

    // Signed overflow case
    load(0, 8'h80); load(1, 8'h01);
    do_run(0, lat, bn);
    check("t6_uo", uo_out, 8'h7F);
    check("t6_borrow", {7'd0, uio_out[6]}, 8'h00);
    check("t6_ovf", {7'd0, uio_out[3]}, {7'd0, OVF_ON});
    check("t6_oe", uio_oe, EXP_OE);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
